// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: shared FSM states, RAM word map and iteration bound for mult_seq_ctrl.
package mult_seq_pkg;
  typedef enum logic [2:0] {IDLE, WR_SUM, WR_DIFF, MUL, WR_LO, WR_HI, DONE} state_t;
  localparam logic [2:0] ADDR_SUM  = 3'd0;
  localparam logic [2:0] ADDR_DIFF = 3'd1;
  localparam logic [2:0] ADDR_PLO  = 3'd2;
  localparam logic [2:0] ADDR_PHI  = 3'd3;
  localparam int ITER_LAST = 15;
endpackage

// File: rtl/mult_seq_dp.sv
// mult_seq_dp: A/Q/M registers with 17-bit add and right shift for the shift-add multiply.
module mult_seq_dp #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             re,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] m_ld,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_step
);
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] d_ld;
  logic [WIDTH:0]   acc;
  logic             c;
  assign m_ld   = x + y;
  assign d_ld   = x - y;
  assign acc    = q[0] ? {1'b0, a} + {1'b0, m} : {1'b0, a};
  assign c      = acc[WIDTH];
  // the carry lands in A's MSB while A's LSB moves into Q
  assign q_step = {acc[0], q[WIDTH-1:1]};
  always_ff @(posedge clk or posedge re)
    if (re) begin
      a <= '0;
      q <= '0;
      m <= '0;
    end else if (load) begin
      a <= '0;
      q <= d_ld;
      m <= m_ld;
    end else if (step) begin
      a <= {c, acc[WIDTH-1:1]};
      q <= q_step;
    end
endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequences (x+y)*(x-y) through a shift-add datapath, logging operands and product to RAM8.
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic             clk,
  input  logic             re,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi,
  output logic             ram_e,
  output logic             ram_w,
  output logic             ram_r,
  output logic [2:0]       ram_addr,
  output logic [WIDTH-1:0] ram_din
);
  localparam int CW = $clog2(ITER);
  state_t           state, nxt;
  logic [CW-1:0]    cnt;
  logic             load, step, wr;
  logic [2:0]       addr;
  logic [WIDTH-1:0] din, m_ld, a, q, q_step;
  mult_seq_dp #(.WIDTH(WIDTH)) u_dp (
    .clk(clk), .re(re), .load(load), .step(step), .x(x), .y(y),
    .m_ld(m_ld), .a(a), .q(q), .q_step(q_step)
  );
  assign ram_r = 1'b0;
  // DONE's exit edge doubles as an accept point so back-to-back ops run every 21 cycles
  always_comb begin
    nxt  = state;
    load = 1'b0;
    step = 1'b0;
    case (state)
      IDLE, DONE: begin
        load = start;
        nxt  = start ? WR_SUM : IDLE;
      end
      WR_SUM:  nxt = WR_DIFF;
      WR_DIFF: nxt = MUL;
      MUL: begin
        step = 1'b1;
        nxt  = (cnt == CW'(ITER_LAST)) ? WR_LO : MUL;
      end
      WR_LO:   nxt = WR_HI;
      WR_HI:   nxt = DONE;
      default: nxt = IDLE;
    endcase
    wr   = nxt inside {WR_SUM, WR_DIFF, WR_LO, WR_HI};
    addr = nxt == WR_SUM ? ADDR_SUM : nxt == WR_DIFF ? ADDR_DIFF : nxt == WR_LO ? ADDR_PLO : ADDR_PHI;
    din  = nxt == WR_SUM ? m_ld : nxt == WR_DIFF ? q : nxt == WR_LO ? q_step : a;
  end
  always_ff @(posedge clk or posedge re)
    if (re) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ram_e    <= 1'b0;
      ram_w    <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      prod_lo  <= '0;
      prod_hi  <= '0;
    end else begin
      state <= nxt;
      cnt   <= load ? '0 : step ? cnt + CW'(1) : cnt;
      busy  <= wr || nxt == MUL;
      done  <= nxt == DONE;
      ram_e <= wr;
      ram_w <= wr;
      if (wr) begin
        ram_addr <= addr;
        ram_din  <= din;
      end
      if (state == WR_HI) begin
        prod_lo <= q;
        prod_hi <= a;
      end
    end
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: directed checks of mult_seq_ctrl with a RAM-write scoreboard.
module tb_mult_seq_ctrl;
  logic        clk = 1'b0;
  logic        re, start;
  logic [15:0] x, y;
  logic        busy, done, ram_e, ram_w, ram_r;
  logic [15:0] prod_lo, prod_hi, ram_din;
  logic [2:0]  ram_addr;
  logic [18:0] sb[$];
  int errors = 0;
  int checks = 0;

  mult_seq_ctrl dut (
    .clk(clk), .re(re), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .prod_lo(prod_lo), .prod_hi(prod_hi),
    .ram_e(ram_e), .ram_w(ram_w), .ram_r(ram_r), .ram_addr(ram_addr), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [15:0] xv, input logic [15:0] yv);
    logic [15:0] s, d;
    s = xv + yv;
    d = xv - yv;
    return {16'h0, s} * {16'h0, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic [18:0] e;
    @(negedge clk);
    if (ram_e === 1'b1 || ram_w === 1'b1) begin
      chk("write_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ram_write", {ram_e, ram_w, ram_addr, ram_din}, {2'b11, e});
      end
    end
  endtask

  task automatic push_ops(input logic [15:0] xv, input logic [15:0] yv, input bit full);
    logic [15:0] s, d;
    logic [31:0] p;
    s = xv + yv;
    d = xv - yv;
    p = model(xv, yv);
    sb.push_back({3'd0, s});
    sb.push_back({3'd1, d});
    if (full) begin
      sb.push_back({3'd2, p[15:0]});
      sb.push_back({3'd3, p[31:16]});
    end
  endtask

  task automatic op(input logic [15:0] xv, input logic [15:0] yv, input int j1, input int j2);
    logic [31:0] p;
    int k, bc;
    bit seen;
    p = model(xv, yv);
    push_ops(xv, yv, 1'b1);
    x = xv;
    y = yv;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("busy_on", busy, 1);
    chk("done_low_after_accept", done, 0);
    k = 0;
    bc = 0;
    seen = 1'b0;
    while (k < 40 && !seen) begin
      if (busy) bc++;
      if (done) seen = 1'b1;
      else begin
        if (k == j1 || k == j2) begin
          x = ~xv;
          y = yv ^ 16'h1234;
          start = 1'b1;
        end else start = 1'b0;
        cyc();
        k++;
      end
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    chk("done_cycle", k, 20);
    chk("busy_cycles", bc, 20);
    chk("busy_off_at_done", busy, 0);
    chk("prod_lo", prod_lo, p[15:0]);
    chk("prod_hi", prod_hi, p[31:16]);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ram_e"}, ram_e, 0);
    chk({tag, "_ram_w"}, ram_w, 0);
    chk({tag, "_ram_r"}, ram_r, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_din"}, ram_din, 0);
    chk({tag, "_prod_lo"}, prod_lo, 0);
    chk({tag, "_prod_hi"}, prod_hi, 0);
  endtask

  initial begin
    re = 1'b1;
    start = 1'b0;
    x = '0;
    y = '0;
    @(negedge clk);
    chk_zero("reset");
    re = 1'b0;
    cyc();
    cyc();
    chk("idle_busy", busy, 0);
    op(16'd3, 16'd1, -1, -1);
    cyc();
    chk("done_pulse_width", done, 0);
    op(16'd1, 16'd3, -1, -1);
    cyc();
    op(16'hFFFF, 16'h0000, -1, -1);
    cyc();
    op(16'h8000, 16'h8000, -1, -1);
    cyc();
    op(16'd7, 16'd2, 4, 19);
    op(16'd9, 16'd4, -1, -1);
    cyc();
    push_ops(16'd5, 16'd3, 1'b0);
    x = 16'd5;
    y = 16'd3;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 9; i++) cyc();
    chk("mid_busy", busy, 1);
    re = 1'b1;
    #1;
    chk_zero("abort");
    chk("abort_sb", sb.size(), 0);
    cyc();
    cyc();
    re = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    chk("post_abort_idle", busy, 0);
    chk("post_abort_no_done", done, 0);
    op(16'd2, 16'd1, -1, -1);
    chk("post_abort_lo", prod_lo, 16'h0003);
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
